// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, latency limits and the latched request bundle.
package dmem_pkg;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic addr_err(
    input logic [31:0] a,
    input int unsigned depth
  );
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Down-counter timing the WAIT phase of a request.
// Expires when one cycle of waiting is left.
module lat_counter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory with store bookkeeping.
// One request in flight; completion is a single ready pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [15:0] store_cnt,
  output logic [31:0] last_wadr,
  output logic [31:0] last_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(LATENCY - 1);

  state_t      r_state;
  state_t      w_next;
  req_t        r_req;
  logic [31:0] r_mem [DEPTH];
  logic [15:0] r_store_cnt;
  logic [31:0] r_last_wadr;
  logic [31:0] r_last_wdata;

  logic          w_accept;
  logic          w_expire;
  logic          w_commit;
  logic          w_wait;
  logic [AW-1:0] w_idx;

  assign w_idx    = r_req.addr[AW+1:2];
  assign w_accept = (r_state == S_IDLE) && req;
  assign w_wait   = (r_state == S_WAIT);
  assign w_commit = (r_state == S_RESP) &&
                    r_req.we && !r_req.err;

  lat_counter u_lat (
    .clk        (clk),
    .rst_n      (reset),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_wait),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_expire) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.we    <= we;
      r_req.err   <= addr_err(addr, DEPTH);
      r_req.addr  <= addr;
      r_req.wdata <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store_cnt  <= '0;
      r_last_wadr  <= '0;
      r_last_wdata <= '0;
    end else if (w_commit) begin
      r_store_cnt  <= r_store_cnt + 16'd1;
      r_last_wadr  <= r_req.addr;
      r_last_wdata <= r_req.wdata;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= r_req.wdata;
    end
  end

  always_comb begin
    ready = (r_state == S_RESP);
    err   = ready && r_req.err;
    rdata = '0;
    if (ready && !r_req.we && !r_req.err) begin
      rdata = r_mem[w_idx];
    end
  end

  assign store_cnt  = r_store_cnt;
  assign last_wadr  = r_last_wadr;
  assign last_wdata = r_last_wdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized check of dmem_responder at LATENCY 2 and 1.
// Reference: word-array model plus request timing rules.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rdata2, rdata1, lwa2, lwa1, lwd2, lwd1;
  logic [15:0] cnt2, cnt1;
  logic        ready2, ready1, err2, err1;

  logic [31:0] rdata_v, lwa_v, lwd_v;
  logic [15:0] cnt_v;
  logic        ready_v, err_v;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk        (clk),
    .reset      (reset),
    .req        (req && !sel),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata2),
    .ready      (ready2),
    .err        (err2),
    .store_cnt  (cnt2),
    .last_wadr  (lwa2),
    .last_wdata (lwd2)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req        (req && sel),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata1),
    .ready      (ready1),
    .err        (err1),
    .store_cnt  (cnt1),
    .last_wadr  (lwa1),
    .last_wdata (lwd1)
  );

  assign rdata_v = sel ? rdata1 : rdata2;
  assign ready_v = sel ? ready1 : ready2;
  assign err_v   = sel ? err1   : err2;
  assign cnt_v   = sel ? cnt1   : cnt2;
  assign lwa_v   = sel ? lwa1   : lwa2;
  assign lwd_v   = sel ? lwd1   : lwd2;

  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  int unsigned m_cnt   [2];
  logic [31:0] m_lwa   [2];
  logic [31:0] m_lwd   [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      m_lwa[s] = '0;
      m_lwd[s] = '0;
    end
  endtask

  task automatic model_store(input int s,
                             input logic [31:0] a,
                             input logic [31:0] d);
    int idx;
    if (!is_bad(a)) begin
      idx = int'(a[31:2]);
      m_mem[s][idx]   = d;
      m_known[s][idx] = 1'b1;
      m_cnt[s]        = (m_cnt[s] + 1) % 65536;
      m_lwa[s]        = a;
      m_lwd[s]        = d;
    end
  endtask

  task automatic chk_regs(input string tag);
    int s;
    s = sel ? 1 : 0;
    chk({tag, "_cnt"}, {16'h0, cnt_v}, m_cnt[s]);
    chk({tag, "_lwa"}, lwa_v, m_lwa[s]);
    chk({tag, "_lwd"}, lwd_v, m_lwd[s]);
  endtask

  task automatic txn(input bit w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    int  s, lat, n, idx;
    bit  e, got;
    s   = sel ? 1 : 0;
    lat = sel ? 1 : 2;
    e   = is_bad(a);
    @(negedge clk);
    we    = w;
    addr  = a;
    wdata = d;
    req   = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ready_v) got = 1'b1;
      else chk("idle_rdata", rdata_v, 32'h0);
    end
    if (!got) begin
      chk("ready_timeout", 32'(got), 32'h1);
    end else begin
      chk("latency", n, lat);
      chk("err", {31'h0, err_v}, {31'h0, e});
      if (!w) begin
        if (e) begin
          chk("err_rdata", rdata_v, 32'h0);
        end else begin
          idx = int'(a[31:2]);
          if (m_known[s][idx])
            chk("load_rdata", rdata_v, m_mem[s][idx]);
        end
      end
    end
    @(negedge clk);
    req   = 1'b0;
    addr  = $urandom;
    wdata = $urandom;
    @(posedge clk);
    #1;
    chk("ready_pulse", {31'h0, ready_v}, 32'h0);
    if (w) model_store(s, a, d);
    chk_regs("post");
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)
      return 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'h1;
    else if (r == 1)
      return 32'((DEPTH + $urandom_range(0, 100)) * 4);
    else if (r < 6)
      return 32'($urandom_range(0, 7) * 4);
    else
      return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_a [4];
    logic [31:0] b2b_d [4];
    int k;
    reset = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    sel   = 1'b0;
    model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        m_known[s][i] = 1'b0;

    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ready", {31'h0, ready_v}, 32'h0);
      chk("rst_err", {31'h0, err_v}, 32'h0);
      chk("rst_rdata", rdata_v, 32'h0);
      chk_regs("rst");
    end
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Store aborted by reset while waiting.
    @(negedge clk);
    we    = 1'b1;
    addr  = 32'd80;
    wdata = 32'd5;
    req   = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_wait", {31'h0, ready_v}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 1'b0;
    model_reset();
    #1;
    chk("abort_rst_ready", {31'h0, ready_v}, 32'h0);
    chk_regs("abort_rst");
    @(posedge clk);
    #1;
    chk("abort_hold", {31'h0, ready_v}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_after", {31'h0, ready_v}, 32'h0);
    chk_regs("abort_after");

    txn(1'b1, 32'd84, 32'd7);
    txn(1'b0, 32'd84, 32'h0);
    txn(1'b1, 32'd84, 32'hFFFF7F02);
    txn(1'b0, 32'd84, 32'h0);
    chk("two_stores", {16'h0, cnt_v}, 32'd2);
    txn(1'b1, 32'd82, 32'h1234);
    txn(1'b1, 32'd256, 32'h5678);
    txn(1'b0, 32'd82, 32'h0);
    txn(1'b0, 32'd256, 32'h0);
    txn(1'b0, 32'd80, 32'h0);

    // LATENCY=1 with req held across four stores.
    for (int i = 0; i < 4; i++) begin
      b2b_a[i] = 32'((i + 3) * 4);
      b2b_d[i] = $urandom;
    end
    @(negedge clk);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = b2b_a[0];
    wdata = b2b_d[0];
    req   = 1'b1;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      chk("b2b_ready", {31'h0, ready_v},
          {31'h0, c[0]});
      if (ready_v) begin
        model_store(1, b2b_a[k], b2b_d[k]);
        k++;
        @(negedge clk);
        if (k < 4) begin
          addr  = b2b_a[k];
          wdata = b2b_d[k];
        end else begin
          req = 1'b0;
        end
      end
    end
    chk("b2b_cnt", {16'h0, cnt_v}, 32'd4);
    chk_regs("b2b");
    for (int i = 0; i < 4; i++)
      txn(1'b0, b2b_a[i], 32'h0);

    sel = 1'b0;
    for (int i = 0; i < 150; i++)
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    sel = 1'b1;
    for (int i = 0; i < 60; i++)
      txn(1'($urandom_range(0, 1)), rand_addr(), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 64: number of 32-bit words in the memory array; power of two, minimum 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to ready; minimum 1, maximum 15.
REQ-003 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port req  input  1: processor memory request; held high until ready is seen.
REQ-006 Port we  input  1: 1 = store, 0 = load; sampled at acceptance.
REQ-007 Port addr  input  32: byte address (dataadr); sampled at acceptance.
REQ-008 Port wdata  input  32: store data (writedata); sampled at acceptance.
REQ-009 Port rdata  output  32: load data; valid only while ready=1.
REQ-010 Port ready  output  1: one-cycle completion pulse for the accepted request.
REQ-011 Port err  output  1: error flag; valid only while ready=1.
REQ-012 Port store_cnt  output  16: number of committed stores.
REQ-013 Port last_wadr  output  32: byte address of the most recent committed store.
REQ-014 Port last_wdata  output  32: data of the most recent committed store.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
- IDLE -> WAIT on req=1.
- WAIT -> RESP when the latency counter expires.
- RESP -> IDLE unconditionally.
REQ-016 A request accepted at rising edge t SHALL latch addr, we and wdata and load the counter so that ready=1 during cycle t+LATENCY; for LATENCY=1 the FSM goes directly IDLE -> RESP.
REQ-017 ready SHALL be 1 only in RESP, for exactly one cycle per accepted request.
REQ-018 req is ignored in WAIT and RESP. The next request is accepted no earlier than the edge that ends RESP, so the back-to-back request period is LATENCY+1 cycles.
REQ-019 A request is in error when latched addr[1:0]!=0 or addr[31:2]>=DEPTH; err=1 in RESP for such a request, else err=0.
REQ-020 A non-error store SHALL write mem[addr[31:2]]=wdata at the edge ending RESP, increment store_cnt and update last_wadr/last_wdata at the same edge.
REQ-021 An error store SHALL not modify memory, store_cnt or last_* registers.
REQ-022 A non-error load SHALL drive rdata=mem[addr[31:2]] during RESP; an error load and every non-RESP cycle SHALL drive rdata=0.
REQ-023 A load issued after a store to the same word SHALL return the stored data, with no bypass hazard given REQ-018.
REQ-024 store_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Memory array contents are not reset; reading a never-written word returns an unspecified value, and the bench SHALL not check it.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, ready=0, err=0, rdata=0, store_cnt=0, last_wadr=0, last_wdata=0, and clear the latency counter and latched request.
REQ-027 A reset asserted in WAIT or RESP SHALL abort the request with no memory write and no ready pulse.
REQ-028 The first request after reset release SHALL be accepted at the first rising edge with reset=1 and req=1.

Structure
REQ-029 FSM state encoding and the MIN_LATENCY/MAX_LATENCY constants SHALL reside in a shared package dmem_pkg.
REQ-030 The latency counter SHALL be one sub-module, lat_counter (load, decrement, expire flag); the memory array and FSM SHALL reside in dmem_responder.

Verification
REQ-031 With LATENCY=2, a store of addr=84, wdata=7 with req at edge 0 -> ready=1, err=0 in cycle 2; after that edge store_cnt=1, last_wadr=84, last_wdata=7.
REQ-032 A load of addr=84 following that store -> rdata=7, err=0 with ready.
REQ-033 A store of addr=84, wdata=0xFFFF7F02 (-33022), then a load of addr=84 -> rdata=0xFFFF7F02; store_cnt=2.
REQ-034 A store to addr=82 (misaligned) or addr=256 (DEPTH=64) -> err=1 with ready; store_cnt and last_* unchanged; a load of the same address -> rdata=0, err=1.
REQ-035 A store of addr=80, wdata=5 with reset pulsed low during WAIT -> no ready pulse, store_cnt=0; a later load of addr=80 is not compared (word never written).
REQ-036 With LATENCY=1, req held high continuously for 4 stores -> ready pulses every 2 cycles, store_cnt=4.
